activation_pipe: RTL and testbench
==================================

ACTIVATION_PIPE -- requirements
Module: activation_pipe

Interface
REQ-001 Parameter N, default 16: signed two's-complement data width.
REQ-002 Parameter Q, default 8: fractional bits of data (Q-format); constraint Q <= N-4, so that 6.0 is representable.
REQ-003 Parameter CHANNELS, default 16: channel-tag range; tag width CW = max(1, $clog2(CHANNELS)).
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_data  in  N  signed input sample.
REQ-007 in_channel  in  CW  channel tag carried alongside the sample.
REQ-008 in_mode  in  2  activation select: 0 ReLU, 1 ReLU6, 2 hard-sigmoid, 3 hard-swish.
REQ-009 in_valid  in  1  input sample valid.
REQ-010 in_ready  out  1  block accepts the sample this cycle.
REQ-011 out_data  out  N  signed activated sample.
REQ-012 out_channel  out  CW  tag of out_data.
REQ-013 out_valid  out  1  output sample valid.
REQ-014 out_ready  in  1  downstream accepts the output.

Function
REQ-015 The block SHALL be a 3-stage pipeline: S1 register inputs, S2 clamp/offset, S3 multiply/shift/saturate, with S3 driving the outputs.
REQ-016 A transfer SHALL occur on a cycle where valid and ready are both 1; in_data, in_channel and in_mode SHALL be sampled together, and the mode SHALL travel with its sample.
REQ-017 in_ready SHALL be (!out_valid || out_ready); when it is 1 all stages advance, and when it is 0 every stage register holds.
REQ-018 Latency SHALL be exactly 3 cycles from input transfer to out_valid when out_ready stays 1; throughput SHALL be 1 sample/cycle.
REQ-019 While stalled, out_data, out_channel and out_valid SHALL remain stable.
REQ-020 Bubbles (in_valid=0 at a transfer cycle) SHALL propagate as invalid stages and SHALL not produce out_valid.
REQ-021 ReLU: out = x if x >= 0, else 0.
REQ-022 ReLU6: out = clamp(x, 0, 6<<Q).
REQ-023 Hard-sigmoid: h = clamp(x + (3<<Q), 0, 6<<Q) computed in N+1 bits; out = (h * 10923) >> 16, unsigned truncation.
REQ-024 Hard-swish: s = hard-sigmoid(x) per REQ-023; out = (x * s) >>> Q, arithmetic shift with truncation toward minus infinity, computed at 2N+1 bits.
REQ-025 All results SHALL saturate to the signed N-bit range [-2^(N-1), 2^(N-1)-1]; wrap-around is forbidden.
REQ-026 out_channel SHALL equal the in_channel of the same transfer; tags SHALL be passed through without range-checking.
REQ-027 When out_valid=0, out_data and out_channel SHALL be driven to 0.
REQ-028 Samples SHALL leave in acceptance order; no sample may be dropped or duplicated under any out_ready pattern.

Reset
REQ-029 While rst=1: out_valid=0, out_data=0, out_channel=0, all stage valids=0, and in_ready=1 (following REQ-017).
REQ-030 Reset mid-stream SHALL discard all in-flight samples; the first output after reset SHALL come from a sample accepted after rst deasserts.
REQ-031 rst SHALL take priority over any simultaneous transfer.

Verification (N=16, Q=8)
REQ-032 ReLU, x=0xFF00 (-1.0) then 0x0180 (1.5) -> outputs 0x0000, 0x0180, out_valid exactly 3 cycles after each input.
REQ-033 ReLU6, x=0x0700 (7.0) -> 0x0600; x=0x0300 -> 0x0300; x=0x8000 -> 0x0000.
REQ-034 Hard-sigmoid, x=0x0000 -> 0x0080; x=0xFC00 (-4.0) -> 0x0000; x=0x0400 (4.0) -> 0x0100.
REQ-035 Hard-swish, x=0x0100 -> 0x00AA; x=0x0300 -> 0x0300; x=0xFD00 (-3.0) -> 0x0000; x=0x7FFF -> 0x7FFF, no wrap.
REQ-036 Stream of 32 samples, mixed modes, channels 0..15, random out_ready (50%) -> every output matches the reference model in order; outputs hold stable while out_ready=0; in_ready follows REQ-017.
REQ-037 rst asserted with 3 samples in flight for one cycle -> no output appears from those samples; a new sample accepted after reset appears 3 cycles later.

Source files
------------

// File: rtl/activation_pipe.sv
// Three-stage streaming activation unit (ReLU, ReLU6, hard-sigmoid, hard-swish)
// on signed Q-format samples with a valid/ready handshake and a channel tag.
module activation_pipe #(
  parameter int unsigned N        = 16,
  parameter int unsigned Q        = 8,
  parameter int unsigned CHANNELS = 16,
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_data,
  input  logic [CW-1:0] in_channel,
  input  logic [1:0]    in_mode,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out_data,
  output logic [CW-1:0] out_channel,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int unsigned WW = 2 * N + 1;
  localparam int unsigned PW = N + 15;

  localparam logic [1:0] MODE_RELU   = 2'd0;
  localparam logic [1:0] MODE_RELU6  = 2'd1;
  localparam logic [1:0] MODE_HSIG   = 2'd2;
  localparam logic [1:0] MODE_HSWISH = 2'd3;

  localparam logic signed [N:0]    SIX   = (N + 1)'(6 << Q);
  localparam logic signed [N:0]    THREE = (N + 1)'(3 << Q);
  localparam logic signed [WW-1:0] MAX_W = {{(N + 2){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_W = {{(N + 2){1'b1}}, {(N - 1){1'b0}}};
  localparam logic signed [N-1:0]  MAX_N = {1'b0, {(N - 1){1'b1}}};
  localparam logic signed [N-1:0]  MIN_N = {1'b1, {(N - 1){1'b0}}};

  function automatic logic signed [N-1:0] sat(input logic signed [WW-1:0] v);
    if (v > MAX_W)      sat = MAX_N;
    else if (v < MIN_W) sat = MIN_N;
    else                sat = v[N-1:0];
  endfunction

  // Whole pipe moves in lockstep: either every stage advances or all hold.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: input register
  logic                 s1_valid;
  logic signed [N-1:0]  s1_data;
  logic [CW-1:0]        s1_ch;
  logic [1:0]           s1_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_ch    <= '0;
      s1_mode  <= MODE_RELU;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_data  <= in_data;
      s1_ch    <= in_channel;
      s1_mode  <= in_mode;
    end
  end

  // S2: clamp for ReLU/ReLU6 and offset+clamp for the hard-sigmoid term
  logic signed [N:0]   x_ext;
  logic signed [N:0]   h_sum;
  logic signed [N:0]   h_clamp;
  logic signed [N-1:0] r_clamp;

  always_comb begin
    x_ext   = (N + 1)'(s1_data);
    h_sum   = x_ext + THREE;
    h_clamp = h_sum;
    if (h_sum < 0)        h_clamp = '0;
    else if (h_sum > SIX) h_clamp = SIX;
    r_clamp = s1_data;
    if (s1_data < 0)                                r_clamp = '0;
    else if (s1_mode == MODE_RELU6 && x_ext > SIX)  r_clamp = N'(SIX);
  end

  logic                 s2_valid;
  logic signed [N-1:0]  s2_x;
  logic signed [N-1:0]  s2_c;
  logic [N:0]           s2_h;
  logic [CW-1:0]        s2_ch;
  logic [1:0]           s2_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_x     <= '0;
      s2_c     <= '0;
      s2_h     <= '0;
      s2_ch    <= '0;
      s2_mode  <= MODE_RELU;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_x     <= s1_data;
      s2_c     <= r_clamp;
      s2_h     <= h_clamp;
      s2_ch    <= s1_ch;
      s2_mode  <= s1_mode;
    end
  end

  // S3: h/6 via *10923>>16, optional x*s product, saturation
  logic [N-1:0]        sig_val;
  logic signed [N-1:0] act;

  always_comb begin
    sig_val = N'((PW'(s2_h) * PW'(10923)) >> 16);
    act     = s2_c;
    case (s2_mode)
      MODE_HSIG:   act = sat(WW'(sig_val));
      MODE_HSWISH: act = sat((WW'(s2_x) * $signed(WW'(sig_val))) >>> Q);
      default:     act = s2_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
    end else if (adv) begin
      out_valid   <= s2_valid;
      out_data    <= s2_valid ? act : '0;
      out_channel <= s2_valid ? s2_ch : '0;
    end
  end

endmodule

// File: tb/tb_activation_pipe.sv
// Directed and randomized scoreboard bench for activation_pipe at N=16, Q=8.
module tb_activation_pipe;

  localparam int unsigned N  = 16;
  localparam int unsigned Q  = 8;
  localparam int unsigned CH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   in_data;
  logic [3:0]    in_channel;
  logic [1:0]    in_mode;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   out_data;
  logic [3:0]    out_channel;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

  activation_pipe #(.N(N), .Q(Q), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_channel(in_channel), .in_mode(in_mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_channel(out_channel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  ch;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b0;
  bit          use_model = 1'b0;
  bit          xfer = 1'b0;
  logic [15:0] dir_exp = '0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic [3:0]  prev_ch = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference using plain integer arithmetic for Q8.8.
  function automatic logic [15:0] ref_act(input logic [15:0] xin, input logic [1:0] m);
    longint x, h, s, r;
    x = longint'($signed(xin));
    h = x + 768;
    if (h < 0)    h = 0;
    if (h > 1536) h = 1536;
    s = (h * 10923) >>> 16;
    case (m)
      2'd0:    r = (x < 0) ? 0 : x;
      2'd1:    r = (x < 0) ? 0 : ((x > 1536) ? 1536 : x);
      2'd2:    r = s;
      default: r = (x * s) >>> 8;
    endcase
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  // One clock: observe at negedge, then step past the next posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    xfer = 1'b0;
    if (rst) begin
      sbq.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_ch", 32'(out_channel), 32'(prev_ch));
      end
      if (!out_valid) begin
        chk("idle_data", 32'(out_data), 32'd0);
        chk("idle_ch", 32'(out_channel), 32'd0);
      end else if (out_ready) begin
        if (sbq.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_ch", 32'(out_channel), 32'(e.ch));
          if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_ch    = out_channel;
      if (in_valid && in_ready) begin
        xfer = 1'b1;
        e.data = use_model ? ref_act(in_data, in_mode) : dir_exp;
        e.ch   = in_channel;
        e.cyc  = cyc;
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] m, input logic [3:0] c,
                      input logic [15:0] exp);
    in_valid   = 1'b1;
    in_data    = d;
    in_mode    = m;
    in_channel = c;
    dir_exp    = exp;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_channel = '0; in_mode = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_channel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Directed vectors, back-to-back, out_ready held high.
    chk_lat = 1'b1;
    use_model = 1'b0;
    send(16'hFF00, 2'd0, 4'd1,  16'h0000);
    send(16'h0180, 2'd0, 4'd2,  16'h0180);
    send(16'h0700, 2'd1, 4'd3,  16'h0600);
    send(16'h0300, 2'd1, 4'd4,  16'h0300);
    send(16'h8000, 2'd1, 4'd5,  16'h0000);
    send(16'h0000, 2'd2, 4'd6,  16'h0080);
    send(16'hFC00, 2'd2, 4'd7,  16'h0000);
    send(16'h0400, 2'd2, 4'd8,  16'h0100);
    send(16'h0100, 2'd3, 4'd9,  16'h00AA);
    send(16'h0300, 2'd3, 4'd10, 16'h0300);
    send(16'hFD00, 2'd3, 4'd11, 16'h0000);
    send(16'h7FFF, 2'd3, 4'd15, 16'h7FFF);
    // Bubbles between samples.
    idle(1);
    send(16'hFF00, 2'd3, 4'd12, 16'hFFAB);
    idle(2);
    send(16'h7FFF, 2'd0, 4'd13, 16'h7FFF);
    idle(6);
    chk("directed_drain", 32'(sbq.size()), 32'd0);

    // Randomized stream with backpressure and occasional bubbles.
    chk_lat = 1'b0;
    use_model = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      in_valid   = 1'b1;
      in_channel = 4'(i % 16);
      in_mode    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       in_data = 16'h7FFF;
        1:       in_data = 16'h8000;
        2:       in_data = 16'($urandom_range(0, 65535));
        default: in_data = 16'($urandom_range(0, 4095)) - 16'd2048;
      endcase
      for (int k = 0; k < 50; k++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        if (xfer) break;
      end
      if (!xfer) chk("accept_timeout", 32'(xfer), 32'd1);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 200 && sbq.size() > 0; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("stream_drain", 32'(sbq.size()), 32'd0);
    out_ready = 1'b1;
    idle(4);

    // Mid-stream reset discards in-flight samples.
    chk_lat = 1'b1;
    send(16'h0100, 2'd0, 4'd1, 16'h0000);
    send(16'h0200, 2'd1, 4'd2, 16'h0000);
    send(16'h0300, 2'd3, 4'd3, 16'h0000);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h0123;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_data", 32'(out_data), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    idle(4);
    send(16'h0180, 2'd1, 4'd14, 16'h0000);
    idle(5);
    chk("post_rst_drain", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
